falling_char_engine: RTL

FALLING_CHAR_ENGINE -- requirements
Module: falling_char_engine

---
 rtl/falling_char_engine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/falling_char_engine.sv
// Falling-character game engine: slot table, key matching, per-frame gravity sweep
// and miss/score accounting behind a RUN/ADVANCE/OVER controller.
module falling_char_engine #(
  parameter int SLOTS      = 8,
  parameter int FLOOR      = 480,
  parameter int MISS_LIMIT = 5,
  parameter int SPEED_W    = 3,
  localparam int IDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_valid,
  output logic               spawn_ready,
  input  logic [7:0]         spawn_char,
  input  logic [9:0]         spawn_x,
  input  logic [SPEED_W-1:0] spawn_speed,
  input  logic               frame_tick,
  input  logic               key_valid,
  input  logic [7:0]         key_char,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_active,
  output logic [7:0]         rd_char,
  output logic [9:0]         rd_x,
  output logic [9:0]         rd_y,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [15:0]        score,
  output logic [3:0]         miss_count,
  output logic               gameover
);

  typedef enum logic [1:0] {RUN, ADVANCE, OVER} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               active_q [SLOTS];
  logic               active_d [SLOTS];
  logic [7:0]         char_q   [SLOTS];
  logic [7:0]         char_d   [SLOTS];
  logic [9:0]         x_q      [SLOTS];
  logic [9:0]         x_d      [SLOTS];
  logic [9:0]         y_q      [SLOTS];
  logic [9:0]         y_d      [SLOTS];
  logic [SPEED_W-1:0] speed_q  [SLOTS];
  logic [SPEED_W-1:0] speed_d  [SLOTS];
  logic [15:0]        score_q, score_d;
  logic [3:0]         miss_q, miss_d;
  logic               hit_q, hit_d;
  logic               missp_q, missp_d;
  logic               over_q, over_d;

  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               hit_found;
  logic [IDX_W-1:0]   hit_idx;
  logic [9:0]         hit_y;
  logic [10:0]        y_sum;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    active_d = active_q;
    char_d   = char_q;
    x_d      = x_q;
    y_d      = y_q;
    speed_d  = speed_q;
    score_d  = score_q;
    miss_d   = miss_q;
    hit_d    = 1'b0;
    missp_d  = 1'b0;
    over_d   = over_q;
    y_sum    = '0;

    // Lowest-index free slot: scan high to low so the last write wins.
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    // Deepest matching slot; strict compare keeps the lowest index on ties.
    hit_found = 1'b0;
    hit_idx   = '0;
    hit_y     = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (active_q[i] && char_q[i] == key_char && (!hit_found || y_q[i] > hit_y)) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_y     = y_q[i];
      end
    end

    spawn_ready = (state_q == RUN) && free_found;

    case (state_q)
      RUN: begin
        if (spawn_valid && spawn_ready) begin
          active_d[free_idx] = 1'b1;
          char_d[free_idx]   = spawn_char;
          x_d[free_idx]      = spawn_x;
          y_d[free_idx]      = '0;
          speed_d[free_idx]  = (spawn_speed == '0) ? SPEED_W'(1) : spawn_speed;
        end
        if (key_valid && hit_found) begin
          active_d[hit_idx] = 1'b0;
          char_d[hit_idx]   = '0;
          x_d[hit_idx]      = '0;
          y_d[hit_idx]      = '0;
          speed_d[hit_idx]  = '0;
          hit_d             = 1'b1;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
        if (frame_tick) begin
          state_d = ADVANCE;
          sweep_d = '0;
        end
      end
      ADVANCE: begin
        if (active_q[sweep_q]) begin
          y_sum = {1'b0, y_q[sweep_q]} + 11'(speed_q[sweep_q]);
          if (y_sum >= 11'(FLOOR)) begin
            active_d[sweep_q] = 1'b0;
            char_d[sweep_q]   = '0;
            x_d[sweep_q]      = '0;
            y_d[sweep_q]      = '0;
            speed_d[sweep_q]  = '0;
            missp_d           = 1'b1;
            if (miss_q != 4'hF) miss_d = miss_q + 4'd1;
          end else begin
            y_d[sweep_q] = y_sum[9:0];
          end
        end
        if (sweep_q == IDX_W'(SLOTS - 1)) begin
          if (miss_d >= 4'(MISS_LIMIT)) begin
            state_d = OVER;
            over_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = OVER;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      sweep_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        active_q[i] <= 1'b0;
        char_q[i]   <= '0;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
        speed_q[i]  <= '0;
      end
      score_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      missp_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      active_q <= active_d;
      char_q   <= char_d;
      x_q      <= x_d;
      y_q      <= y_d;
      speed_q  <= speed_d;
      score_q  <= score_d;
      miss_q   <= miss_d;
      hit_q    <= hit_d;
      missp_q  <= missp_d;
      over_q   <= over_d;
    end
  end

  assign rd_active  = active_q[rd_idx];
  assign rd_char    = char_q[rd_idx];
  assign rd_x       = x_q[rd_idx];
  assign rd_y       = y_q[rd_idx];
  assign hit_pulse  = hit_q;
  assign miss_pulse = missp_q;
  assign score      = score_q;
  assign miss_count = miss_q;
  assign gameover   = over_q;

endmodule
